// File: rtl/prog_loader.sv
// Program loader and run controller: streams host words into instruction memory,
// pulses the CPU start line, then times the run until done or timeout.
module prog_loader #(
    parameter int unsigned D            = 10,
    parameter int unsigned W            = 9,
    parameter int unsigned START_CYCLES = 2,
    parameter int unsigned TIMEOUT      = 4095
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         in_last,
    output logic         imem_we,
    output logic [D-1:0] imem_addr,
    output logic [W-1:0] imem_wdata,
    output logic         start,
    input  logic         done,
    output logic [D:0]   prog_len,
    output logic [15:0]  cycle_count,
    output logic         finished,
    output logic [1:0]   error,
    input  logic         ack
);

    typedef enum logic [2:0] {
        StIdle, StLoad, StDrain, StStart, StRun, StFinish, StErr
    } state_e;

    localparam int unsigned ScW        = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
    localparam logic [D:0]  LastAddr   = {1'b0, {D{1'b1}}};
    localparam logic [15:0] TimeoutCnt = 16'(TIMEOUT);
    localparam logic [ScW-1:0] StartLast = ScW'(START_CYCLES - 1);

    state_e         state;
    logic [ScW-1:0] start_cnt;
    logic           xfer;
    logic [15:0]    cycle_next;

    assign in_ready   = (state == StIdle) || (state == StLoad);
    assign xfer       = in_valid && in_ready;
    assign cycle_next = cycle_count + 16'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= StIdle;
            start_cnt   <= '0;
            imem_we     <= 1'b0;
            imem_addr   <= '0;
            imem_wdata  <= '0;
            start       <= 1'b0;
            prog_len    <= '0;
            cycle_count <= '0;
            finished    <= 1'b0;
            error       <= 2'd0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                StIdle, StLoad: begin
                    // prog_len is 0 in IDLE, so it doubles as the next write address
                    if (xfer) begin
                        imem_we    <= 1'b1;
                        imem_addr  <= prog_len[D-1:0];
                        imem_wdata <= in_data;
                        prog_len   <= prog_len + (D+1)'(1);
                        if (in_last) begin
                            state <= StDrain;
                        end else if (prog_len == LastAddr) begin
                            state <= StErr;
                            error <= 2'd1;
                        end else begin
                            state <= StLoad;
                        end
                    end
                end
                StDrain: begin
                    state     <= StStart;
                    start     <= 1'b1;
                    start_cnt <= '0;
                end
                StStart: begin
                    if (start_cnt == StartLast) begin
                        start <= 1'b0;
                        state <= StRun;
                    end else begin
                        start_cnt <= start_cnt + ScW'(1);
                    end
                end
                StRun: begin
                    if (done) begin
                        finished <= 1'b1;
                        state    <= StFinish;
                    end else begin
                        cycle_count <= cycle_next;
                        if (cycle_next == TimeoutCnt) begin
                            state <= StErr;
                            error <= 2'd2;
                        end
                    end
                end
                StFinish, StErr: begin
                    if (ack) begin
                        state       <= StIdle;
                        prog_len    <= '0;
                        cycle_count <= '0;
                        finished    <= 1'b0;
                        error       <= 2'd0;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/prog_loader.md
# prog_loader

Host-side program loader and run controller for the 9-bit custom CPU. It accepts a stream of 9-bit machine-code words over a valid/ready handshake and writes them sequentially from address 0 into the instruction memory write port. It then pulses the CPU `start` and counts cycles until the CPU raises `done`, and reports completion, cycle count or error to the host. It sits between the test host/bench and the CPU top level, driving the write side of the instruction memory that the CPU fetches from.

## Interface
Parameters:
- D, 10, instruction memory address width (matches CPU program counter width)
- W, 9, instruction word width
- START_CYCLES, 2, number of cycles `start` is held high (≥1)
- TIMEOUT, 4095, maximum RUN cycles before timeout error (≤ 65535)

Ports:
- clk  input  1  single system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- in_valid  input  1  host word valid
- in_ready  output  1  loader can accept a word
- in_data  input  W  machine-code word
- in_last  input  1  marks final word of program
- imem_we  output  1  instruction memory write enable
- imem_addr  output  D  instruction memory write address
- imem_wdata  output  W  instruction memory write data
- start  output  1  CPU start/hold (CPU PC held at reset value while high)
- done  input  1  CPU done flag
- prog_len  output  D+1  number of words loaded
- cycle_count  output  16  CPU run cycles, done-exclusive
- finished  output  1  run completed normally
- error  output  2  0 none, 1 overflow, 2 timeout
- ack  input  1  host acknowledge; returns loader to IDLE from FINISH/ERR

## Operation
- States: IDLE, LOAD, DRAIN, START, RUN, FINISH, ERR.
- Handshake: a word transfers on a rising edge where in_valid && in_ready. in_ready = 1 in IDLE and LOAD, 0 elsewhere; it is combinational from state only.
- IDLE: prog_len = 0, cycle_count = 0. First transfer writes address 0 and moves to LOAD, or to DRAIN if in_last.
- LOAD: each transfer writes the next address (prog_len). A transfer with in_last moves to DRAIN.
- Overflow: a transfer at address 2^D−1 without in_last writes the word, then moves to ERR with error = 1.
- DRAIN: one cycle; the last write completes; start stays 0.
- START: start = 1 for exactly START_CYCLES cycles; done is ignored; then RUN.
- RUN: start = 0. cycle_count increments each cycle done is sampled 0. Done sampled 1 moves to FINISH, with cycle_count unchanged on that edge. cycle_count reaching TIMEOUT moves to ERR with error = 2.
- FINISH: finished = 1. ERR: error holds its code. Both hold all outputs until ack is sampled 1, then return to IDLE and clear prog_len, cycle_count, finished and error.
- ack is ignored in all other states. in_valid is ignored outside IDLE/LOAD.
- Width rules: prog_len is D+1 bits so that a full 2^D load is representable. cycle_count never wraps.

## Timing
- Reset (reset = 0, asynchronous) forces state IDLE.
  - Output values under reset: imem_we = 0, imem_addr = 0, imem_wdata = 0, start = 0, prog_len = 0, cycle_count = 0, finished = 0, error = 0, in_ready = 1.
  - Reset mid-operation aborts immediately. A write in flight is dropped.
- Write latency: a transfer at edge n registers imem_we = 1, imem_addr and imem_wdata for the cycle following edge n (one cycle). imem_we is 0 in every cycle without a preceding transfer.
- Back-to-back transfers sustain one write per cycle.
- Last transfer at edge n: DRAIN during cycle n..n+1, start high from edge n+1 for START_CYCLES cycles, RUN entered at edge n+1+START_CYCLES.
- done is sampled synchronously. finished rises on the edge after done is seen in RUN.

## Test plan
- Load 3 words 0x0A5, 0x1FF, 0x000 (last on third), done held 0 → imem writes to addresses 0, 1, 2 with matching data on consecutive cycles; prog_len = 3; start high exactly 2 cycles; state reaches RUN.
- Same load, then done asserted 10 cycles after RUN entry → finished = 1, cycle_count = 10, error = 0; ack → all cleared, in_ready = 1.
- in_valid toggled with gaps and a single-word program (in_last on first word) → exactly one write at address 0, DRAIN then start, no extra writes.
- D = 2, stream 5 words without in_last → addresses 0–3 written, error = 1 after 4th transfer, in_ready = 0, 5th word not accepted.
- TIMEOUT = 20, done held 0 → error = 2 with cycle_count = 20; ack returns to IDLE.
- Reset asserted during START and during LOAD → outputs go to their reset values asynchronously; a subsequent clean load from address 0 succeeds.
